// File: rtl/newton_seq_ctrl.sv
// Sequencer for a digit-serial Newton datapath: loads operand digits, runs N_ITER
// passes that feed each result back into x_buf, and streams the final pass out.
module newton_seq_ctrl #(
   parameter int WIDTH    = 128,
   parameter int N_ITER   = 5,
   parameter int DP_DELAY = 3
) (
   input  logic       clk,
   input  logic       asyn_reset,
   input  logic       start,
   output logic       busy,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_x,
   input  logic [1:0] in_b,
   output logic       dp_clear,
   output logic       dp_en,
   output logic [1:0] dp_x,
   output logic [1:0] dp_b,
   input  logic [1:0] dp_res,
   output logic       out_valid,
   output logic [1:0] out_digit,
   output logic       out_last,
   output logic       done
);

   localparam int CW = $clog2(WIDTH + DP_DELAY);
   localparam int IW = $clog2(N_ITER + 1);
   localparam int AW = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LOAD_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] C_RUN_LAST  = CW'(WIDTH + DP_DELAY - 1);
   localparam logic [CW-1:0] C_DLY       = CW'(DP_DELAY);
   localparam logic [CW-1:0] C_W         = CW'(WIDTH);
   localparam logic [IW-1:0] I_LAST      = IW'(N_ITER - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_DONE} state_t;

   state_t          r_state, w_state_next;
   logic [CW-1:0]   r_cnt, w_cnt_next;
   logic [IW-1:0]   r_iter, w_iter_next;
   logic [1:0]      r_x_buf [0:WIDTH-1];
   logic [1:0]      r_b_buf [0:WIDTH-1];

   logic            w_ld_wr, w_sample, w_final, w_emit, w_rd_en;
   logic [AW-1:0]   w_ld_addr, w_fb_addr, w_rd_addr;

   logic            r_busy, r_in_ready, r_dp_clear, r_dp_en;
   logic [1:0]      r_dp_x, r_dp_b, r_out_digit;
   logic            r_out_valid, r_out_last, r_done;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_iter_next  = r_iter;
      w_ld_wr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_LOAD;
               w_cnt_next   = '0;
               w_iter_next  = '0;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               w_ld_wr = 1'b1;
               if (r_cnt == C_LOAD_LAST) begin
                  w_state_next = S_CLEAR;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt + CW'(1);
               end
            end
         end
         S_CLEAR: begin
            w_state_next = S_RUN;
            w_cnt_next   = '0;
         end
         S_RUN: begin
            if (r_cnt == C_RUN_LAST) begin
               w_cnt_next = '0;
               if (r_iter == I_LAST) begin
                  w_state_next = S_DONE;
               end else begin
                  w_state_next = S_CLEAR;
                  w_iter_next  = r_iter + IW'(1);
               end
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Result digit k arrives DP_DELAY cycles after x_buf[k] was presented, so the
   // write-back slot always trails the read pointer and needs no hazard check.
   assign w_sample  = (r_state == S_RUN) && (r_cnt >= C_DLY);
   assign w_final   = (r_iter == I_LAST);
   assign w_emit    = w_sample && w_final;
   assign w_ld_addr = AW'(r_cnt);
   assign w_fb_addr = AW'(r_cnt - C_DLY);
   assign w_rd_en   = (w_state_next == S_RUN) && (w_cnt_next < C_W);
   assign w_rd_addr = AW'(w_cnt_next);

   always_ff @(posedge clk) begin
      if (w_ld_wr) begin
         r_x_buf[w_ld_addr] <= in_x;
         r_b_buf[w_ld_addr] <= in_b;
      end else if (w_sample) begin
         r_x_buf[w_fb_addr] <= dp_res;
      end
   end

   always_ff @(posedge clk) begin
      if (asyn_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_iter      <= '0;
         r_busy      <= 1'b0;
         r_in_ready  <= 1'b0;
         r_dp_clear  <= 1'b0;
         r_dp_en     <= 1'b0;
         r_dp_x      <= 2'b00;
         r_dp_b      <= 2'b00;
         r_out_valid <= 1'b0;
         r_out_digit <= 2'b00;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_iter      <= w_iter_next;
         r_busy      <= (w_state_next != S_IDLE);
         r_in_ready  <= (w_state_next == S_LOAD);
         r_dp_clear  <= (w_state_next == S_CLEAR);
         r_dp_en     <= (w_state_next == S_RUN);
         r_dp_x      <= w_rd_en ? r_x_buf[w_rd_addr] : 2'b00;
         r_dp_b      <= w_rd_en ? r_b_buf[w_rd_addr] : 2'b00;
         r_out_valid <= w_emit;
         r_out_digit <= w_emit ? dp_res : 2'b00;
         r_out_last  <= w_emit && (r_cnt == C_RUN_LAST);
         r_done      <= (w_state_next == S_DONE);
      end
   end

   assign busy      = r_busy;
   assign in_ready  = r_in_ready;
   assign dp_clear  = r_dp_clear;
   assign dp_en     = r_dp_en;
   assign dp_x      = r_dp_x;
   assign dp_b      = r_dp_b;
   assign out_valid = r_out_valid;
   assign out_digit = r_out_digit;
   assign out_last  = r_out_last;
   assign done      = r_done;

endmodule

// File: tb/tb_newton_seq_ctrl.sv
// Three sequencer instances (4/1/1 identity, 4/2/1 xor, default xor) against an
// operation-level model; literal latencies and digit streams pin the model.
module tb_newton_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pw(int i); return (i == 2) ? 128 : 4; endfunction
   function automatic int pn(int i); return (i == 0) ? 1 : ((i == 1) ? 2 : 5); endfunction
   function automatic int pd(int i); return (i == 2) ? 3 : 1; endfunction

   logic [2:0]      st, rs, iv;
   logic [2:0][1:0] ix, ib;
   logic [2:0]      d_busy, d_rdy, d_clr, d_en, d_ov, d_ol, d_done;
   logic [2:0][1:0] d_x, d_b, d_od, d_res;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int LW = pw(gi);
         localparam int LN = pn(gi);
         localparam int LD = pd(gi);
         logic [1:0] pipe [0:LD-1];
         always @(posedge clk) begin
            pipe[0] <= (gi == 0) ? d_x[gi] : (d_x[gi] ^ d_b[gi]);
            for (int i = 1; i < LD; i++) pipe[i] <= pipe[i-1];
         end
         assign d_res[gi] = pipe[LD-1];
         newton_seq_ctrl #(.WIDTH(LW), .N_ITER(LN), .DP_DELAY(LD)) u_dut (
            .clk(clk), .asyn_reset(rs[gi]), .start(st[gi]), .busy(d_busy[gi]),
            .in_valid(iv[gi]), .in_ready(d_rdy[gi]), .in_x(ix[gi]), .in_b(ib[gi]),
            .dp_clear(d_clr[gi]), .dp_en(d_en[gi]), .dp_x(d_x[gi]), .dp_b(d_b[gi]),
            .dp_res(d_res[gi]), .out_valid(d_ov[gi]), .out_digit(d_od[gi]),
            .out_last(d_ol[gi]), .done(d_done[gi]));
      end
   endgenerate

   int checks = 0;
   int errors = 0;

   // Operation-level model: 0 idle, 1 loading, 2 processing since m_tend.
   int         m_st [3];
   int         m_k [3];
   int         m_tend [3];
   logic [1:0] m_x [3][128];
   logic [1:0] m_b [3][128];
   logic [1:0] obs [3][256];
   int         obs_n [3];
   logic [1:0] sx [128];
   logic [1:0] sb [128];

   // p Newton passes of the mock datapath applied to one digit.
   function automatic logic [1:0] fpow(int id, logic [1:0] x, logic [1:0] b, int p);
      if (id == 0) return x;
      return (p % 2 == 1) ? (x ^ b) : x;
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_st[i] = 0; m_k[i] = 0; m_tend[i] = 0; obs_n[i] = 0;
      end
   end

   always @(negedge clk) begin : p_cmp
      int W, N, D, P, r, q, c, j;
      logic e_busy, e_rdy, e_clr, e_en, e_ov, e_ol, e_done;
      logic [1:0] e_x, e_b, e_od;
      logic [12:0] ev, av;
      for (int id = 0; id < 3; id++) begin
         W = pw(id); N = pn(id); D = pd(id); P = 1 + W + D;
         e_busy = 0; e_rdy = 0; e_clr = 0; e_en = 0; e_ov = 0; e_ol = 0; e_done = 0;
         e_x = 0; e_b = 0; e_od = 0;
         if (m_st[id] == 1) begin
            e_busy = 1; e_rdy = 1;
         end else if (m_st[id] == 2) begin
            e_busy = 1;
            r = cyc - m_tend[id];
            if (r <= N * P) begin
               q = (r - 1) % P;
               if (q == 0) e_clr = 1;
               else begin
                  e_en = 1; c = q - 1;
                  if (c < W) begin
                     e_x = fpow(id, m_x[id][c], m_b[id][c], (r - 1) / P);
                     e_b = m_b[id][c];
                  end
               end
            end else e_done = 1;
            j = r - ((N - 1) * P + 3 + D);
            if (j >= 0 && j < W) begin
               e_ov = 1; e_od = fpow(id, m_x[id][j], m_b[id][j], N); e_ol = (j == W - 1);
            end
         end
         ev = {e_busy, e_rdy, e_clr, e_en, e_x, e_b, e_ov, e_od, e_ol, e_done};
         av = {d_busy[id], d_rdy[id], d_clr[id], d_en[id], d_x[id], d_b[id], d_ov[id],
               (e_ov ? d_od[id] : 2'b00), d_ol[id], d_done[id]};
         checks++;
         if (av !== ev) begin
            errors++;
            $display("FAIL outputs dut%0d cycle %0d got %b expected %b", id, cyc, av, ev);
         end
         if (d_ov[id]) begin
            obs[id][obs_n[id] % 256] = d_od[id];
            obs_n[id]++;
         end
         if (rs[id]) m_st[id] = 0;
         else if (m_st[id] == 0) begin
            if (st[id]) begin m_st[id] = 1; m_k[id] = 0; end
         end else if (m_st[id] == 1) begin
            if (iv[id]) begin
               m_x[id][m_k[id]] = ix[id]; m_b[id][m_k[id]] = ib[id]; m_k[id]++;
               if (m_k[id] == W) begin m_st[id] = 2; m_tend[id] = cyc; end
            end
         end else if (cyc - m_tend[id] == N * P + 1) m_st[id] = 0;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_vec(input logic [7:0] xv, input logic [7:0] bv);
      for (int k = 0; k < 4; k++) begin
         sx[k] = xv[7-2*k -: 2];
         sb[k] = bv[7-2*k -: 2];
      end
   endtask

   task automatic set_rand(input int w);
      for (int k = 0; k < w; k++) begin
         sx[k] = 2'($urandom_range(0, 3));
         sb[k] = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic chk_beats(input string name, input int id, input int base, input logic [7:0] xv);
      for (int k = 0; k < 4; k++) chk(name, int'(obs[id][(base + k) % 256]), int'(xv[7-2*k -: 2]));
   endtask

   task automatic run_op(input int id, input int stall_mask, input bit rnd, input bit extra,
                         output int lat, output int nb, output int base);
      int s, li, k, n;
      bit v, seen;
      base = obs_n[id];
      st[id] = 1; s = cyc;
      @(posedge clk); #1;
      k = 0; li = 0;
      while (k < pw(id) && li < 2000) begin
         v = rnd ? ($urandom_range(0, 3) != 0) : (((stall_mask >> li) & 1) == 0);
         iv[id] = v; ix[id] = sx[k]; ib[id] = sb[k];
         st[id] = extra && (li == 1);
         @(posedge clk); #1;
         if (v) k++;
         li++;
      end
      iv[id] = 0; ix[id] = 0; ib[id] = 0; st[id] = 0;
      seen = 0; n = 0;
      while (!seen && n < 3000) begin
         if (d_done[id]) seen = 1;
         else begin
            st[id] = extra && (n == 7);
            @(posedge clk); #1;
            n++;
         end
      end
      lat = cyc - s;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout dut%0d got no done expected done within bound", id);
      end
      st[id] = extra;
      @(posedge clk); #1;
      st[id] = 0;
      nb = obs_n[id] - base;
      $display("op dut%0d latency %0d beats %0d", id, lat, nb);
   endtask

   initial begin : p_stim
      int lat, nb, base, s;
      rs = '1; st = '0; iv = '0; ix = '0; ib = '0;
      repeat (3) @(posedge clk);
      #1 rs = '0;
      @(posedge clk); #1;

      set_vec(8'b11_01_10_00, 8'h00);
      run_op(0, 0, 0, 0, lat, nb, base);
      chk("single_pass_latency", lat, 11); chk("single_pass_beats", nb, 4);
      chk_beats("single_pass_digit", 0, base, 8'b11_01_10_00);

      set_vec(8'b11_10_01_00, 8'b01_01_01_01);
      run_op(1, 0, 0, 0, lat, nb, base);
      chk("double_xor_latency", lat, 17); chk("double_xor_beats", nb, 4);
      chk_beats("double_xor_digit", 1, base, 8'b11_10_01_00);

      set_vec(8'b11_01_10_00, 8'h00);
      run_op(0, 32'b0110, 0, 0, lat, nb, base);
      chk("stall_latency", lat, 13);
      chk_beats("stall_digit", 0, base, 8'b11_01_10_00);

      set_rand(128);
      run_op(2, 0, 0, 1, lat, nb, base);
      chk("default_latency", lat, 789); chk("default_beats", nb, 128);

      for (int i = 0; i < 6; i++) begin
         set_rand(4);
         run_op(i % 2, 0, 1, i >= 4, lat, nb, base);
         chk("random_beats", nb, 4);
      end

      // Reset lands in the third RUN cycle of the first pass.
      set_rand(4);
      base = obs_n[1];
      st[1] = 1; s = cyc;
      @(posedge clk); #1;
      st[1] = 0;
      for (int k = 0; k < 4; k++) begin
         iv[1] = 1; ix[1] = sx[k]; ib[1] = sb[k];
         @(posedge clk); #1;
      end
      iv[1] = 0;
      while (cyc < s + 8) begin @(posedge clk); #1; end
      rs[1] = 1;
      @(posedge clk); #1;
      rs[1] = 0;
      chk("midrun_reset_busy", int'(d_busy[1]), 0);
      chk("midrun_reset_en", int'(d_en[1]), 0);
      repeat (12) @(posedge clk);
      #1 chk("midrun_reset_no_beats", obs_n[1] - base, 0);
      set_rand(4);
      run_op(1, 0, 0, 0, lat, nb, base);
      chk("after_reset_latency", lat, 17); chk("after_reset_beats", nb, 4);

      st[0] = 1; rs[0] = 1;
      @(posedge clk); #1;
      st[0] = 0; rs[0] = 0;
      chk("start_reset_busy", int'(d_busy[0]), 0);
      chk("start_reset_ready", int'(d_rdy[0]), 0);
      @(posedge clk); #1;
      chk("start_reset_idle", int'(d_busy[0]), 0);

      repeat (2) @(posedge clk);
      #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : p_watchdog
      #500000;
      $display("FAIL watchdog got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/newton_seq_ctrl.md
NEWTON_SEQ_CTRL -- requirements
Module: newton_seq_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 128, meaning digits per operand (>=2).
REQ-002 SHALL provide parameter N_ITER, default 5, meaning Newton passes per operation (>=1).
REQ-003 SHALL provide parameter DP_DELAY, default 3, meaning datapath online delay in cycles (>=1).
REQ-004 SHALL have port clk input 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port asyn_reset input 1, a synchronous, active-high reset.
REQ-006 SHALL have port start input 1, request a new operation.
REQ-007 SHALL have port busy output 1, high in any state other than IDLE.
REQ-008 SHALL have ports in_valid input 1 and in_ready output 1, forming the operand digit handshake.
REQ-009 SHALL have ports in_x input 2 and in_b input 2, carrying the operand x and b digits, MSD first.
REQ-010 SHALL have port dp_clear output 1, the datapath state clear.
REQ-011 SHALL have port dp_en output 1, the datapath digit strobe.
REQ-012 SHALL have ports dp_x output 2 and dp_b output 2, the digits presented to the datapath.
REQ-013 SHALL have port dp_res input 2, the datapath result digit.
REQ-014 SHALL have ports out_valid output 1, out_digit output 2 and out_last output 1, the final result stream.
REQ-015 SHALL have port done output 1, a one-cycle completion pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, CLEAR, RUN and DONE.
REQ-017 SHALL, in IDLE with start=1, move to LOAD and clear the digit and iteration counters; start in any other state SHALL be ignored.
REQ-018 SHALL, in LOAD, hold in_ready=1, and each cycle with in_valid=1 SHALL write in_x/in_b to x_buf[k]/b_buf[k] and increment k.
REQ-019 SHALL treat in_valid=0 in LOAD as a stall: k is held and nothing is written.
REQ-020 SHALL, on the WIDTH-th accepted digit, move to CLEAR; in_ready SHALL be 0 outside LOAD.
REQ-021 SHALL, in CLEAR (exactly 1 cycle), assert dp_clear=1 with dp_en=0, then move to RUN with RUN cycle counter c=0.
REQ-022 SHALL, in RUN, assert dp_en=1 for c=0..WIDTH+DP_DELAY-1, giving WIDTH+DP_DELAY cycles per pass.
REQ-023 SHALL, in RUN with c<WIDTH, drive dp_x=x_buf[c] and dp_b=b_buf[c].
REQ-024 SHALL, in RUN with c>=WIDTH, drive dp_x=dp_b=2'b00 as flush digits.
REQ-025 SHALL, in RUN with c>=DP_DELAY, sample dp_res at the clock edge and write it to x_buf[c-DP_DELAY].
REQ-026 SHALL order each x_buf read of index k (cycle k) before its write (cycle k+DP_DELAY), with no other hazard logic.
REQ-027 SHALL, on the last RUN cycle of a non-final pass, increment the iteration counter and return to CLEAR.
REQ-028 SHALL, on the last RUN cycle of the final pass, go to DONE.
REQ-029 SHALL, during the final pass only, drive out_valid=1 and out_digit=dp_res in each sampling cycle c=DP_DELAY..WIDTH+DP_DELAY-1, i.e. exactly WIDTH beats.
REQ-030 SHALL assert out_last with the WIDTH-th output beat; there is no output backpressure.
REQ-031 SHALL, in DONE (1 cycle), assert done=1 and then return to IDLE; a start arriving in DONE SHALL be ignored.
REQ-032 SHALL drive dp_clear, dp_en, dp_x, dp_b, out_valid, out_digit, out_last, done, busy and in_ready from registers (no combinational path from inputs).
REQ-033 SHALL drive dp_x/dp_b=00 and dp_en=0 whenever not in RUN.
REQ-034 SHALL, with in_valid held high and start seen in cycle 0, pulse done in cycle WIDTH+N_ITER*(1+WIDTH+DP_DELAY)+1.
REQ-035 SHALL size counters as clog2(WIDTH+DP_DELAY) bits for c and clog2(N_ITER+1) bits for the iteration counter, with no wrap inside a pass.

Reset
REQ-036 SHALL, on asyn_reset=1 at a rising edge, enter IDLE and clear all counters.
REQ-037 SHALL hold every output at 0 after reset until a new start.
REQ-038 SHALL handle reset mid-operation (LOAD/CLEAR/RUN/DONE) with the same behaviour; no partial result is emitted afterwards.
REQ-039 SHALL NOT reset x_buf/b_buf, whose contents after reset are don't-care.
REQ-040 SHALL give asyn_reset priority over start in the same cycle.

Verification
REQ-041 WIDTH=4, N_ITER=1, DP_DELAY=1, mock datapath dp_res=dp_x delayed 1 cycle, x=3,1,2,0, in_valid held high -> out_digit 3,1,2,0, out_last on the 4th beat, done at cycle 11.
REQ-042 WIDTH=4, N_ITER=2, DP_DELAY=1, mock dp_res=(dp_x XOR dp_b) delayed 1, x=3,2,1,0 and b=1,1,1,1 -> output 3,2,1,0 (double XOR), done at cycle 17.
REQ-043 Same as REQ-041 with in_valid low on the 2nd and 3rd LOAD cycles -> in_ready stays 1, identical output, done 2 cycles later (cycle 13).
REQ-044 Default parameters, start pulsed again while busy -> ignored, exactly 128 output beats, done at cycle 789.
REQ-045 Reset asserted in the 3rd RUN cycle of pass 1 -> next cycle all outputs 0, busy=0; a following start runs a full correct operation.
REQ-046 start and asyn_reset high in the same cycle -> remains IDLE, busy=0, in_ready=0.
